debounce_sync: RTL and testbench



---
 rtl/debounce_pkg.sv | 36 +++
 rtl/sync_ff.sv | 38 +++
 rtl/debounce_sync.sv | 181 ++++++++++++++++++
 tb/tb_debounce_sync.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the debounce_sync input-conditioning block.
//   Holds the FSM state encoding, the glitch-counter width and a small
//   saturating-increment helper used by the optional glitch counter.
//
//   Optional feature macro referenced by users of this package:
//     DEBOUNCE_GLITCH_CNT_EN - enables the rejected-glitch counter output
//                              on debounce_sync.

package debounce_pkg;

    // State encoding is fixed so that bit 1 always reflects the level
    // currently presented on dout, and bit 0 marks "checking a change".
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        CHK_HIGH  = 2'b01,
        IDLE_HIGH = 2'b10,
        CHK_LOW   = 2'b11
    } state_t;

    localparam int GLITCH_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [GLITCH_CNT_W-1:0] satInc(
        input logic [GLITCH_CNT_W-1:0] value
    );
        logic [GLITCH_CNT_W-1:0] result;
        if (value == {GLITCH_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(GLITCH_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff
//   Parameterised N-stage flip-flop synchroniser for a single asynchronous
//   bit. The flops form a plain shift chain with no logic between stages so
//   that each stage has a full clock period to resolve metastability.
//
//   Parameters:
//     N       - number of synchroniser stages (2..4 intended)
//
//   Ports:
//     i_clk   - sampling clock, rising edge
//     i_rst_n - synchronous active-low reset, clears every stage to 0
//     i_d     - asynchronous input bit
//     o_q     - synchronised output (last stage)

module sync_ff #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_stages;

    // Shift chain: the raw input enters bit 0 and walks towards bit N-1.
    // Reset is sampled on the clock edge only; there is no async path.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[N-2:0], i_d};
        end
    end

    assign o_q = r_stages[N-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync
//   Synchronises a bouncy asynchronous 1-bit input into the clk domain,
//   filters out short glitches and presents a clean registered level plus
//   single-cycle rise/fall strobes. Feeds the d input of the downstream
//   storage flop.
//
//   A new level is only accepted after DEBOUNCE_CYCLES consecutive
//   synchronised samples at that level; any sample back at the old level
//   aborts the check and the count starts again from scratch.
//
//   Parameters:
//     SYNC_STAGES     - synchroniser depth (2..4)
//     DEBOUNCE_CYCLES - consecutive samples needed to accept a change (>= 2)
//
//   Ports:
//     i_clk          - system clock, rising edge
//     i_rst_n        - synchronous active-low reset
//     i_din          - raw asynchronous input
//     o_dout         - debounced level (registered)
//     o_rise_pulse   - one-cycle strobe on dout 0->1 (registered)
//     o_fall_pulse   - one-cycle strobe on dout 1->0 (registered)
//     o_glitch_cnt   - saturating count of rejected glitches; present only
//                      when DEBOUNCE_GLITCH_CNT_EN is defined
//
//   Optional feature macro: DEBOUNCE_GLITCH_CNT_EN

module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_din,
    output logic                    o_dout,
    output logic                    o_rise_pulse,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic                    o_fall_pulse,
    output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
`else
    output logic                    o_fall_pulse
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_dinS;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;

    state_t           w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_doutNext;
    logic             w_riseNext;
    logic             w_fallNext;

    // Bring the raw input into the clk domain before anything looks at it.
    sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_din),
        .o_q     (w_dinS)
    );

    // State, counter, level and strobe registers. Reset puts everything
    // back to the quiet low state, which also aborts any check in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_dout  <= w_doutNext;
            r_rise  <= w_riseNext;
            r_fall  <= w_fallNext;
        end
    end

    // Next-state logic. Entering a CHK state counts the first new-value
    // sample as 1, so reaching CNT_MAX while still seeing the new value
    // means DEBOUNCE_CYCLES consecutive samples have been observed. The
    // counter is cleared on every exit from CHK so it never exceeds
    // CNT_MAX and never carries a partial count across a bounce.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_doutNext  = r_dout;
        w_riseNext  = 1'b0;
        w_fallNext  = 1'b0;

        case (r_state)
            IDLE_LOW: begin
                if (w_dinS) begin
                    w_stateNext = CHK_HIGH;
                    w_cntNext   = CNT_ONE;
                end
            end

            CHK_HIGH: begin
                if (!w_dinS) begin
                    w_stateNext = IDLE_LOW;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_stateNext = IDLE_HIGH;
                    w_cntNext   = '0;
                    w_doutNext  = 1'b1;
                    w_riseNext  = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end

            IDLE_HIGH: begin
                if (!w_dinS) begin
                    w_stateNext = CHK_LOW;
                    w_cntNext   = CNT_ONE;
                end
            end

            CHK_LOW: begin
                if (w_dinS) begin
                    w_stateNext = IDLE_HIGH;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_stateNext = IDLE_LOW;
                    w_cntNext   = '0;
                    w_doutNext  = 1'b0;
                    w_fallNext  = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_stateNext = IDLE_LOW;
                w_cntNext   = '0;
                w_doutNext  = 1'b0;
            end
        endcase
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] r_glitchCnt;
    logic                    w_abort;

    // A glitch is a CHK state seeing the old level again before the count
    // completed. A reset that interrupts a check is not counted.
    assign w_abort = ((r_state == CHK_HIGH) && !w_dinS) ||
                     ((r_state == CHK_LOW)  &&  w_dinS);

    // Saturating rejected-glitch counter so a noisy input cannot wrap it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_glitchCnt <= '0;
        end else if (w_abort) begin
            r_glitchCnt <= satInc(r_glitchCnt);
        end
    end

    assign o_glitch_cnt = r_glitchCnt;
`endif

    assign o_dout       = r_dout;
    assign o_rise_pulse = r_rise;
    assign o_fall_pulse = r_fall;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync
//   Self-checking bench for debounce_sync with SYNC_STAGES=2 and
//   DEBOUNCE_CYCLES=4, so an accepted change appears 5 edges after the
//   first edge that samples the new input level.
//   Inputs are changed 1 ns after a rising edge and outputs are checked at
//   that same point, i.e. each check sees the result of the edge just taken.
//   Define DEBOUNCE_GLITCH_CNT_EN to also check the glitch counter.

`timescale 1ns/1ps

module tb_debounce_sync;

    logic clk;
    logic rstN;
    logic din;
    logic dout;
    logic risePulse;
    logic fallPulse;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitchCnt;
`endif

    int checkCount;
    int errCount;

    typedef struct {
        logic rstN;
        logic din;
        logic expDout;
        logic expRise;
        logic expFall;
    } vec_t;

    vec_t vecs[24];

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_din        (din),
        .o_dout       (dout),
        .o_rise_pulse (risePulse),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .o_fall_pulse (fallPulse),
        .o_glitch_cnt (glitchCnt)
`else
        .o_fall_pulse (fallPulse)
`endif
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs, take the rising edge, and settle 1 ns.
    task automatic applyStimulus(input logic stimRstN, input logic stimDin);
        rstN = stimRstN;
        din  = stimDin;
        @(posedge clk);
        #1;
    endtask

    // Compare {dout, rise, fall} against the hand-computed values.
    task automatic checkOutput(input string name, input logic expDout,
                               input logic expRise, input logic expFall);
        logic [2:0] got;
        logic [2:0] want;
        got  = {dout, risePulse, fallPulse};
        want = {expDout, expRise, expFall};
        checkCount++;
        if (got !== want) begin
            errCount++;
            $display("[TB] FAIL %s: dout/rise/fall got %b required %b at %0t",
                     name, got, want, $time);
        end
    endtask

    // Repeat the same inputs for n cycles, checking the same outputs each time.
    task automatic runSeq(input string name, input int n, input logic stimRstN,
                          input logic stimDin, input logic expDout,
                          input logic expRise, input logic expFall);
        for (int i = 0; i < n; i++) begin
            applyStimulus(stimRstN, stimDin);
            checkOutput(name, expDout, expRise, expFall);
        end
    endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
    task automatic checkGlitch(input string name, input logic [7:0] expCnt);
        checkCount++;
        if (glitchCnt !== expCnt) begin
            errCount++;
            $display("[TB] FAIL %s: glitch_cnt got %0d required %0d",
                     name, glitchCnt, expCnt);
        end
    endtask
`endif

    task automatic setVec(input int idx, input logic r, input logic d,
                          input logic ed, input logic er, input logic ef);
        vecs[idx].rstN    = r;
        vecs[idx].din     = d;
        vecs[idx].expDout = ed;
        vecs[idx].expRise = er;
        vecs[idx].expFall = ef;
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        rstN       = 1'b0;
        din        = 1'b1;

        // Reset held 3 cycles with din=1, then release with din still 1:
        // the first edge with rstN=1 is row 3, so rise lands on row 8.
        for (int i = 0; i < 3; i++) setVec(i, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 8; i++) setVec(i, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        setVec(8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        setVec(9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // Low glitch of 3 din cycles while dout=1: rejected, no pulse.
        for (int i = 10; i < 13; i++) setVec(i, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 13; i < 17; i++) setVec(i, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // Clean fall: din=0 from row 17, fall pulse on row 22.
        for (int i = 17; i < 22; i++) setVec(i, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        setVec(22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        setVec(23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] starting table vectors");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].expDout,
                        vecs[i].expRise, vecs[i].expFall);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (i == 2) checkGlitch("glitchAfterReset", 8'd0);
`endif
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkGlitch("glitchAfterLowGlitch", 8'd1);
`endif

        // High glitch of 3 din cycles from dout=0: 3 samples, rejected.
        $display("[TB] glitch reject sequence");
        runSeq("glitchHighOn", 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runSeq("glitchHighOff", 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkGlitch("glitchAfterHighGlitch", 8'd2);
`endif

        // Bounce 1,1,0 then a run of 1s starting at B3: rise only at B8.
        $display("[TB] bounce sequence");
        runSeq("bounceA", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runSeq("bounceB", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runSeq("bounceRun", 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runSeq("bounceRise", 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runSeq("bounceHold", 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkGlitch("glitchAfterBounce", 8'd3);
`endif

        // Reset from dout=1 drops dout without a fall pulse.
        $display("[TB] reset mid-check sequence");
        runSeq("rstFromHigh", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkGlitch("glitchCleared", 8'd0);
`endif
        runSeq("rstSettle", 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // din=1 long enough for the FSM to be two samples into the check,
        // then a single reset cycle aborts it.
        runSeq("chkBeforeRst", 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runSeq("rstMidChk", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // With din still 1 the rise must take the full latency again.
        runSeq("afterRstWait", 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runSeq("afterRstRise", 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runSeq("afterRstHold", 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkGlitch("glitchNoCountOnRst", 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
